// File: rtl/filter_seq_ctrl.sv
// Sample FIFO, issue sequencer and coefficient shadow/apply control
// in front of the IIR filter datapath.
module filter_seq_ctrl #(
  parameter int DW    = 11,
  parameter int DEPTH = 4,
  parameter int MAXIF = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          cfg_we,
  input  logic [DW-1:0] cfg_a1,
  input  logic [DW-1:0] cfg_b1,
  input  logic [DW-1:0] cfg_b0,
  output logic          cfg_pending,
  output logic          flt_vin,
  output logic [DW-1:0] flt_din,
  output logic [DW-1:0] flt_a1,
  output logic [DW-1:0] flt_b1,
  output logic [DW-1:0] flt_b0,
  input  logic          flt_vout,
  output logic          busy,
  output logic          err_spur
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int IFW = $clog2(MAXIF + 1);
  localparam logic [CW-1:0]  FULL  = CW'(DEPTH);
  localparam logic [IFW-1:0] IFMAX = IFW'(MAXIF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_LOAD
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IFW-1:0]  infl_q, infl_d;
  logic            pend_q, pend_d;
  logic            err_q, err_d;
  logic            vin_q, vin_d;
  logic [DW-1:0]   din_q, din_d;
  logic [DW-1:0]   sh_a1_q, sh_a1_d;
  logic [DW-1:0]   sh_b1_q, sh_b1_d;
  logic [DW-1:0]   sh_b0_q, sh_b0_d;
  logic [DW-1:0]   a1_q, a1_d;
  logic [DW-1:0]   b1_q, b1_d;
  logic [DW-1:0]   b0_q, b0_d;
  logic            push, issue, vout_ok;

  always_comb begin
    push    = s_valid && (cnt_q != FULL);
    // no issue once a coefficient update is pending
    issue   = (state_q == S_RUN) && !pend_q &&
              (cnt_q != '0) && (infl_q < IFMAX);
    vout_ok = flt_vout && (infl_q != '0);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (issue) rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d  = cnt_q + CW'(push) - CW'(issue);
    infl_d = infl_q + IFW'(issue) - IFW'(vout_ok);
    err_d  = err_q | (flt_vout && (infl_q == '0));

    vin_d = issue;
    din_d = issue ? mem_q[rd_ptr_q] : din_q;

    sh_a1_d = sh_a1_q;
    sh_b1_d = sh_b1_q;
    sh_b0_d = sh_b0_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    b0_d    = b0_q;
    pend_d  = pend_q;
    if (state_q == S_LOAD) begin
      a1_d   = sh_a1_q;
      b1_d   = sh_b1_q;
      b0_d   = sh_b0_q;
      pend_d = 1'b0;
    end
    if (cfg_we) begin
      sh_a1_d = cfg_a1;
      sh_b1_d = cfg_b1;
      sh_b0_d = cfg_b0;
      pend_d  = 1'b1;
    end

    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q) state_d = S_DRAIN;
        else if (cnt_q != '0) state_d = S_RUN;
      end
      S_RUN: begin
        if (pend_q) state_d = S_DRAIN;
        else if (cnt_q == '0) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if ((infl_q == '0) && !vin_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (cfg_we) state_d = S_DRAIN;
        else if (cnt_q != '0) state_d = S_RUN;
        else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      infl_q   <= '0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      vin_q    <= 1'b0;
      din_q    <= '0;
      sh_a1_q  <= '0;
      sh_b1_q  <= '0;
      sh_b0_q  <= '0;
      a1_q     <= '0;
      b1_q     <= '0;
      b0_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      infl_q   <= infl_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      vin_q    <= vin_d;
      din_q    <= din_d;
      sh_a1_q  <= sh_a1_d;
      sh_b1_q  <= sh_b1_d;
      sh_b0_q  <= sh_b0_d;
      a1_q     <= a1_d;
      b1_q     <= b1_d;
      b0_q     <= b0_d;
    end
  end

  assign s_ready     = (cnt_q != FULL);
  assign cfg_pending = pend_q;
  assign flt_vin     = vin_q;
  assign flt_din     = din_q;
  assign flt_a1      = a1_q;
  assign flt_b1      = b1_q;
  assign flt_b0      = b0_q;
  assign err_spur    = err_q;
  assign busy        = (cnt_q != '0) || (infl_q != '0) ||
                       (state_q != S_IDLE);

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Directed bench for filter_seq_ctrl: a vector table for streaming
// and MAXIF behaviour, hand sequences for full/drain/reset cases.
module tb_filter_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [10:0] s_data;
  logic        cfg_we;
  logic [10:0] cfg_a1, cfg_b1, cfg_b0;
  logic        cfg_pending;
  logic        flt_vin;
  logic [10:0] flt_din, flt_a1, flt_b1, flt_b0;
  logic        flt_vout;
  logic        busy;
  logic        err_spur;

  int total = 0;
  int bad   = 0;
  logic rdy_pre;

  localparam logic [10:0] CA1 = 11'h010;
  localparam logic [10:0] CB1 = 11'h080;
  localparam logic [10:0] CB0 = 11'h100;

  filter_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_we(cfg_we), .cfg_a1(cfg_a1), .cfg_b1(cfg_b1),
    .cfg_b0(cfg_b0), .cfg_pending(cfg_pending),
    .flt_vin(flt_vin), .flt_din(flt_din),
    .flt_a1(flt_a1), .flt_b1(flt_b1), .flt_b0(flt_b0),
    .flt_vout(flt_vout), .busy(busy), .err_spur(err_spur)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [10:0] sd;
    logic        we;
    logic        vo;
    logic        vin;
    logic [10:0] din;
    logic        pend;
    logic        busy;
    logic        cf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic sv, logic [10:0] sd, logic we,
                             logic vo, logic vin, logic [10:0] din,
                             logic pend, logic bz, logic cf);
    vec_t r;
    r.sv = sv; r.sd = sd; r.we = we; r.vo = vo;
    r.vin = vin; r.din = din; r.pend = pend;
    r.busy = bz; r.cf = cf;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step(logic sv, logic [10:0] sd, logic we,
                      logic [10:0] a1, logic [10:0] b1,
                      logic [10:0] b0, logic vo);
    @(negedge clk);
    s_valid = sv; s_data = sd; cfg_we = we;
    cfg_a1 = a1; cfg_b1 = b1; cfg_b0 = b0; flt_vout = vo;
    #1 rdy_pre = s_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, CA1, CB1, CB0, 0);
  endtask

  task automatic push(logic [10:0] d);
    step(1, d, 0, CA1, CB1, CB0, 0);
  endtask

  task automatic vout();
    step(0, 0, 0, CA1, CB1, CB0, 1);
  endtask

  task automatic chk_reset(string p);
    chk({p, "_rdy"}, s_ready, 1);
    chk({p, "_vin"}, flt_vin, 0);
    chk({p, "_din"}, flt_din, 0);
    chk({p, "_pend"}, cfg_pending, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_err"}, err_spur, 0);
    chk({p, "_coef"}, {flt_a1, flt_b1, flt_b0}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    logic [10:0] q[$];
    int acc, got, idx;
    bit novin, found;

    // T2: configure then stream 3,5,7
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, 3, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(1, 5, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(1, 7, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 3, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 5, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 7, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 7, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 7, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 7, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 7, 0, 0, 1));
    // T5: issue with simultaneous vout, then MAXIF stall
    tbl.push_back(v(1, 9, 0, 0, 0, 7, 0, 1, 1));
    tbl.push_back(v(1, 10, 0, 0, 0, 7, 0, 1, 1));
    tbl.push_back(v(1, 11, 0, 0, 1, 9, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 1, 1, 10, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 11, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 11, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 11, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 11, 0, 0, 1));
    tbl.push_back(v(1, 20, 0, 0, 0, 11, 0, 1, 1));
    tbl.push_back(v(1, 21, 0, 0, 0, 11, 0, 1, 1));
    tbl.push_back(v(1, 22, 0, 0, 1, 20, 0, 1, 1));
    tbl.push_back(v(1, 23, 0, 0, 1, 21, 0, 1, 1));
    tbl.push_back(v(1, 24, 0, 0, 1, 22, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 23, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 23, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 23, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 24, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 24, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 24, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 24, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 24, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 24, 0, 0, 1));

    // T1: reset held two cycles with s_valid high
    rst = 1; s_valid = 1; s_data = 11'h5; cfg_we = 0;
    cfg_a1 = CA1; cfg_b1 = CB1; cfg_b0 = CB0; flt_vout = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("t1");
    @(negedge clk);
    rst = 0; s_valid = 0;
    @(posedge clk);
    #1;
    chk_reset("t1_post");

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      step(t.sv, t.sd, t.we, CA1, CB1, CB0, t.vo);
      chk($sformatf("row%0d_rdy", i), s_ready, 1);
      chk($sformatf("row%0d_vin", i), flt_vin, t.vin);
      chk($sformatf("row%0d_din", i), flt_din, t.din);
      chk($sformatf("row%0d_pend", i), cfg_pending, t.pend);
      chk($sformatf("row%0d_busy", i), busy, t.busy);
      chk($sformatf("row%0d_coef", i), {flt_a1, flt_b1, flt_b0},
          t.cf ? {CA1, CB1, CB0} : 33'd0);
    end

    // T3: FIFO fills while draining two in-flight samples
    push(30); push(31); idle(); idle(); idle();
    step(0, 0, 1, 11'h1, 11'h2, 11'h3, 0);
    acc = 0; novin = 1;
    for (int i = 0; i < 6; i++) begin
      step(1, 11'(40 + i), 0, CA1, CB1, CB0, 0);
      if (rdy_pre) begin
        acc++;
        q.push_back(11'(40 + i));
      end
      if (flt_vin) novin = 0;
    end
    chk("t3_acc", acc, 4);
    chk("t3_full_rdy", s_ready, 0);
    chk("t3_novin", novin, 1);
    chk("t3_old_b0", flt_b0, CB0);
    vout(); vout();
    got = 0;
    for (int i = 0; i < 12 && got < 4; i++) begin
      idle();
      if (flt_vin) begin
        if (got == 0)
          chk("t3_newcoef", {flt_a1, flt_b1, flt_b0},
              {11'h1, 11'h2, 11'h3});
        chk($sformatf("t3_din%0d", got), flt_din, q.pop_front());
        got++;
      end
    end
    chk("t3_got", got, 4);
    chk("t3_rdy_after", s_ready, 1);
    repeat (4) vout();

    // T4: coefficient change while two samples in flight
    push(50); push(51); push(52);
    step(0, 0, 1, 11'h1, 11'h2, 11'h7FF, 0);
    chk("t4_issue51", {flt_vin, flt_din}, {1'b1, 11'd51});
    chk("t4_pend", cfg_pending, 1);
    novin = 1;
    for (int i = 0; i < 4; i++) begin
      idle();
      if (flt_vin || flt_b0 != 11'h3) novin = 0;
    end
    chk("t4_hold", novin, 1);
    vout(); vout();
    found = 0; idx = -1;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (flt_b0 == 11'h7FF) begin
        found = 1; idx = i;
        break;
      end
    end
    chk("t4_found", found, 1);
    chk("t4_when", idx, 1);
    chk("t4_load_vin", flt_vin, 0);
    chk("t4_load_pend", cfg_pending, 0);
    idle();
    chk("t4_resume", {flt_vin, flt_din}, {1'b1, 11'd52});
    vout(); idle();
    chk("t4_idle_busy", busy, 0);

    // T6: spurious vout, then reset during DRAIN
    chk("t6_err0", err_spur, 0);
    vout();
    chk("t6_err1", err_spur, 1);
    chk("t6_busy", busy, 0);
    idle();
    chk("t6_sticky", err_spur, 1);
    push(60); push(61); push(62);
    step(0, 0, 1, 11'h4, 11'h5, 11'h6, 0);
    push(63); idle();
    chk("t6_drain_busy", busy, 1);
    chk("t6_drain_pend", cfg_pending, 1);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 0;
    chk_reset("t6_rst");
    push(70);
    chk("t6_lat1", flt_vin, 0);
    idle();
    chk("t6_lat2", flt_vin, 0);
    idle();
    chk("t6_first", {flt_vin, flt_din}, {1'b1, 11'd70});
    vout();
    chk("t6_clean", {busy, err_spur}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
